// File: rtl/mem_byte_sequencer_pkg.sv
// rtl/mem_byte_sequencer_pkg.sv - shared types and constants for the byte sequencer
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int   BYTES_PER_WORD = 4;
    localparam int   BEAT_W         = 2;
    localparam logic RW_READ        = 1'b1;
    localparam logic WB_WORD        = 1'b1;

    // Big-endian: beat 0 carries the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [BEAT_W-1:0] beat);
        logic [7:0] b;
        case (beat)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// rtl/mem_byte_sequencer_if.sv - MFA/MFC handshake and MAR/MBR bus bundle
interface mem_byte_sequencer_if;

    logic        MFA;
    logic        READ_WRITE;
    logic        WORD_BYTE;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;
    logic        Busy;

    modport master (
        output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
        input  DataOut, MFC, Busy
    );

    modport slave (
        input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
        output DataOut, MFC, Busy
    );

endinterface

// File: rtl/mem_byte_sequencer_ram.sv
// rtl/mem_byte_sequencer_ram.sv - single-port 8-bit RAM with registered read
module byte_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - serialises word/byte MFA requests onto a byte-wide RAM
module mem_byte_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    mem_byte_sequencer_if.slave   bus
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic                wb_q, wb_d;
    logic [31:0]         din_q, din_d;
    logic                issue_done_q, issue_done_d;
    logic                rd_vld_q, rd_vld_d;
    logic [31:0]         asm_q, asm_d;
    logic [31:0]         dout_q, dout_d;

    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [7:0]          ram_wdata;
    logic [7:0]          ram_rdata;
    logic                last_beat;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^bus.Address[31:ADDR_W];

    byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (Clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wb_q         <= 1'b0;
            din_q        <= '0;
            issue_done_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            asm_q        <= '0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wb_q         <= wb_d;
            din_q        <= din_d;
            issue_done_q <= issue_done_d;
            rd_vld_q     <= rd_vld_d;
            asm_q        <= asm_d;
            dout_q       <= dout_d;
        end
    end

    // Word beats replace the low two address bits, so an unaligned word reads its own aligned word.
    assign ram_addr  = (wb_q == WB_WORD) ? {addr_q[ADDR_W-1:2], beat_q} : addr_q;
    assign ram_wdata = (wb_q == WB_WORD) ? word_byte(din_q, beat_q) : din_q[7:0];
    assign last_beat = (wb_q == WB_WORD) ? (beat_q == BEAT_W'(BYTES_PER_WORD - 1)) : 1'b1;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        wb_d         = wb_q;
        din_d        = din_q;
        issue_done_d = issue_done_q;
        rd_vld_d     = 1'b0;
        asm_d        = asm_q;
        dout_d       = dout_q;
        ram_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.MFA) begin
                    state_d      = ACCESS;
                    addr_d       = bus.Address[ADDR_W-1:0];
                    rw_d         = bus.READ_WRITE;
                    wb_d         = bus.WORD_BYTE;
                    din_d        = bus.DataIn;
                    beat_d       = '0;
                    issue_done_d = 1'b0;
                    asm_d        = '0;
                end
            end
            ACCESS: begin
                if (!issue_done_q) begin
                    ram_we   = (rw_q != RW_READ) && !Reset;
                    rd_vld_d = (rw_q == RW_READ);
                    if (last_beat) begin
                        if (rw_q != RW_READ) begin
                            state_d = DONE;
                        end else begin
                            issue_done_d = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                // Read data trails the issued address by one cycle; the final byte completes the access.
                if (rd_vld_q) begin
                    asm_d = {asm_q[23:0], ram_rdata};
                    if (issue_done_q) begin
                        dout_d  = asm_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.MFA) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Busy    = (state_q == ACCESS);
    assign bus.MFC     = (state_q == DONE);
    assign bus.DataOut = dout_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - scoreboard bench for mem_byte_sequencer
module tb_mem_byte_sequencer;

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int          checks;
    int          errors;
    exp_t        sb_q[$];
    logic [31:0] exp_dout;
    logic        mfc_prev;

    mem_byte_sequencer_if bus ();

    mem_byte_sequencer #(.ADDR_W(10)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every MFC rising edge consumes one scoreboard entry.
    initial mfc_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.MFC === 1'b1 && mfc_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_mfc", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("mfc_latency", cyc, e.cyc);
                chk("dataout", bus.DataOut, e.data);
                chk("busy_at_mfc", {31'd0, bus.Busy}, 32'd0);
            end
        end
        mfc_prev = bus.MFC;
    end

    task automatic wait_mfc();
        for (int i = 0; i < 20; i++) begin
            if (bus.MFC === 1'b1) break;
            @(negedge clk);
        end
        if (bus.MFC !== 1'b1) chk("mfc_timeout", {31'd0, bus.MFC}, 32'd1);
    endtask

    task automatic do_access(input logic rw, input logic wb, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] rd_exp,
                             input int lat, input int hold);
        exp_t e;
        @(negedge clk);
        bus.READ_WRITE = rw;
        bus.WORD_BYTE  = wb;
        bus.Address    = addr;
        bus.DataIn     = data;
        bus.MFA        = 1'b1;
        if (rw) exp_dout = rd_exp;
        e.cyc  = cyc + 1 + lat;
        e.data = exp_dout;
        sb_q.push_back(e);
        @(negedge clk);
        chk("busy_after_e0", {31'd0, bus.Busy}, 32'd1);
        wait_mfc();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("mfc_hold", {31'd0, bus.MFC}, 32'd1);
            chk("no_restart", {31'd0, bus.Busy}, 32'd0);
        end
        bus.MFA = 1'b0;
        @(negedge clk);
        chk("mfc_drop", {31'd0, bus.MFC}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        exp_t e;
        checks     = 0;
        errors     = 0;
        exp_dout   = 32'h0;
        reset      = 1'b1;
        bus.MFA        = 1'b0;
        bus.READ_WRITE = 1'b0;
        bus.WORD_BYTE  = 1'b0;
        bus.Address    = 32'h0;
        bus.DataIn     = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_mfc", {31'd0, bus.MFC}, 32'd0);
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_dataout", bus.DataOut, 32'h0);
        reset = 1'b0;

        do_access(1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0, 4, 0);
        do_access(1'b1, 1'b1, 32'h010, 32'h0, 32'hDEADBEEF, 5, 0);
        do_access(1'b1, 1'b0, 32'h012, 32'h0, 32'h000000BE, 2, 0);
        do_access(1'b0, 1'b0, 32'h011, 32'h00000055, 32'h0, 1, 0);
        do_access(1'b1, 1'b1, 32'h010, 32'h0, 32'hDE55BEEF, 5, 0);
        do_access(1'b1, 1'b1, 32'h013, 32'h0, 32'hDE55BEEF, 5, 0);
        do_access(1'b1, 1'b0, 32'h013, 32'h0, 32'h000000EF, 2, 0);
        do_access(1'b1, 1'b0, 32'h011, 32'h0, 32'h00000055, 2, 10);

        // One-cycle MFA pulse on a byte write.
        @(negedge clk);
        bus.READ_WRITE = 1'b0;
        bus.WORD_BYTE  = 1'b0;
        bus.Address    = 32'h020;
        bus.DataIn     = 32'h000000A7;
        bus.MFA        = 1'b1;
        e.cyc  = cyc + 2;
        e.data = exp_dout;
        sb_q.push_back(e);
        @(negedge clk);
        chk("pulse_busy", {31'd0, bus.Busy}, 32'd1);
        chk("pulse_pre", {31'd0, bus.MFC}, 32'd0);
        bus.MFA = 1'b0;
        @(negedge clk);
        chk("pulse_hi", {31'd0, bus.MFC}, 32'd1);
        @(negedge clk);
        chk("pulse_lo", {31'd0, bus.MFC}, 32'd0);
        do_access(1'b1, 1'b0, 32'h020, 32'h0, 32'h000000A7, 2, 0);

        // Reset after beats 0 and 1 of a word write.
        @(negedge clk);
        bus.READ_WRITE = 1'b0;
        bus.WORD_BYTE  = 1'b1;
        bus.Address    = 32'h010;
        bus.DataIn     = 32'h11223344;
        bus.MFA        = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.Busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b1;
        bus.MFA = 1'b0;
        @(negedge clk);
        chk("abort_mfc", {31'd0, bus.MFC}, 32'd0);
        chk("abort_busy_lo", {31'd0, bus.Busy}, 32'd0);
        chk("abort_dataout", bus.DataOut, 32'h0);
        reset    = 1'b0;
        exp_dout = 32'h0;
        do_access(1'b1, 1'b1, 32'h010, 32'h0, 32'h1122BEEF, 5, 0);

        do_access(1'b0, 1'b1, 32'h0000_03FC, 32'hCAFEF00D, 32'h0, 4, 0);
        do_access(1'b1, 1'b1, 32'hFFFF_F3FC, 32'h0, 32'hCAFEF00D, 5, 0);
        do_access(1'b1, 1'b0, 32'hFFFF_F3FF, 32'h0, 32'h0000000D, 2, 0);

        // Reset and MFA on the same edge: reset wins, request taken one edge later.
        @(negedge clk);
        reset          = 1'b1;
        bus.READ_WRITE = 1'b1;
        bus.WORD_BYTE  = 1'b0;
        bus.Address    = 32'h3FC;
        bus.MFA        = 1'b1;
        @(negedge clk);
        chk("rst_mfa_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_mfa_dout", bus.DataOut, 32'h0);
        reset    = 1'b0;
        exp_dout = 32'h000000CA;
        e.cyc    = cyc + 3;
        e.data   = exp_dout;
        sb_q.push_back(e);
        @(negedge clk);
        chk("rst_mfa_accept", {31'd0, bus.Busy}, 32'd1);
        wait_mfc();
        bus.MFA = 1'b0;
        @(negedge clk);
        chk("rst_mfa_drop", {31'd0, bus.MFC}, 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
